trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller for the RISC-V core. Generalises the existing misalignment detector with full synchronous exception decode and vectored interrupt prioritisation over NUM_IRQ platform lines (level or edge, per channel). Exceptions decode at instruction commit, and interrupts gate on mstatus.MIE/mie. It holds one trap request to the core's CSR/fetch logic under a req/ack handshake and issues MRET pulses. It sits between the commit stage and the CSR file; mtvec redirection and CSR writes stay in the processor.

---
 rtl/trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: synchronises interrupt sources, prioritises interrupts over
// commit-stage exceptions, and holds one trap request under a req/ack handshake.
module trap_ctrl #(
    parameter int unsigned        XLEN     = 32,
    parameter int unsigned        NUM_IRQ  = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               instr_valid,
    input  logic [XLEN-1:0]    pc,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic               illegal,
    input  logic               mstatus_mie,
    input  logic [XLEN-1:0]    mie,
    input  logic               irq_sw,
    input  logic               irq_timer,
    input  logic               irq_ext,
    input  logic [NUM_IRQ-1:0] irq_plat,
    input  logic               trap_ack,
    output logic               trap_req,
    output logic [XLEN-1:0]    trap_cause,
    output logic [XLEN-1:0]    trap_val,
    output logic [XLEN-1:0]    trap_epc,
    output logic               mret_req,
    output logic [XLEN-1:0]    mip_out
);

    localparam int unsigned NSRC        = NUM_IRQ + 3;
    localparam logic [31:0] InstrMret   = 32'h3020_0073;
    localparam logic [31:0] InstrEcall  = 32'h0000_0073;
    localparam logic [31:0] InstrEbreak = 32'h0010_0073;
    localparam logic [6:0]  OpLoad      = 7'b0000011;
    localparam logic [6:0]  OpStore     = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StTrap, StMret} state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    cause_q, cause_d, val_q, val_d, epc_q, epc_d;
    logic [NSRC-1:0]    sync1_q, sync2_q;
    logic [NUM_IRQ-1:0] plat_dly_q, edge_q, edge_d, edge_clr, plat_rise, plat_pend;
    logic [XLEN-1:0]    mip, elig;
    logic               irq_hit, exc_hit, misal, unused_elig;
    logic [XLEN-2:0]    irq_code, exc_code;
    logic [XLEN-1:0]    exc_val;

    // Edge detect compares against one more delayed sample of the synchronised level.
    assign plat_rise = sync2_q[NSRC-1:3] & ~plat_dly_q;
    assign plat_pend = (IRQ_EDGE & edge_q) | (~IRQ_EDGE & sync2_q[NSRC-1:3]);
    assign edge_d    = ((edge_q & ~edge_clr) | plat_rise) & IRQ_EDGE;

    always_comb begin
        mip               = '0;
        mip[3]            = sync2_q[0];
        mip[7]            = sync2_q[1];
        mip[11]           = sync2_q[2];
        mip[16+:NUM_IRQ]  = plat_pend;
    end

    assign elig        = {XLEN{mstatus_mie}} & mie & mip;
    assign unused_elig = ^elig;

    // Later assignments win: platform lines (highest index last) beat MEIP, MSIP, MTIP.
    always_comb begin
        irq_hit  = 1'b0;
        irq_code = '0;
        if (elig[7])  begin irq_hit = 1'b1; irq_code = (XLEN-1)'(7);  end
        if (elig[3])  begin irq_hit = 1'b1; irq_code = (XLEN-1)'(3);  end
        if (elig[11]) begin irq_hit = 1'b1; irq_code = (XLEN-1)'(11); end
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (elig[16+i]) begin
                irq_hit  = 1'b1;
                irq_code = (XLEN-1)'(16 + i);
            end
        end
    end

    assign misal = ((instr[13:12] == 2'b01) && mem_addr[0]) ||
                   ((instr[13:12] == 2'b10) && (mem_addr[1:0] != 2'b00));

    always_comb begin
        exc_hit  = 1'b1;
        exc_code = '0;
        exc_val  = '0;
        if (pc[1:0] != 2'b00) begin
            exc_val  = pc;
        end else if (illegal) begin
            exc_code = (XLEN-1)'(2);
            exc_val  = XLEN'(instr);
        end else if (instr == InstrEbreak) begin
            exc_code = (XLEN-1)'(3);
            exc_val  = pc;
        end else if ((instr[6:0] == OpLoad) && misal) begin
            exc_code = (XLEN-1)'(4);
            exc_val  = mem_addr;
        end else if ((instr[6:0] == OpStore) && misal) begin
            exc_code = (XLEN-1)'(6);
            exc_val  = mem_addr;
        end else if (instr == InstrEcall) begin
            exc_code = (XLEN-1)'(11);
        end else begin
            exc_hit  = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        val_d    = val_q;
        epc_d    = epc_q;
        edge_clr = '0;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    if (irq_hit) begin
                        cause_d = {1'b1, irq_code};
                        val_d   = '0;
                        epc_d   = pc;
                        state_d = StTrap;
                    end else if (exc_hit) begin
                        cause_d = {1'b0, exc_code};
                        val_d   = exc_val;
                        epc_d   = pc;
                        state_d = StTrap;
                    end else if (instr == InstrMret) begin
                        state_d = StMret;
                    end
                end
            end
            StTrap: begin
                if (trap_ack) begin
                    state_d = StIdle;
                    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                        if (cause_q == {1'b1, (XLEN-1)'(16 + i)}) edge_clr[i] = 1'b1;
                    end
                end
            end
            StMret:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cause_q    <= '0;
            val_q      <= '0;
            epc_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            plat_dly_q <= '0;
            edge_q     <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            val_q      <= val_d;
            epc_q      <= epc_d;
            sync1_q    <= {irq_plat, irq_ext, irq_timer, irq_sw};
            sync2_q    <= sync1_q;
            plat_dly_q <= sync2_q[NSRC-1:3];
            edge_q     <= edge_d;
        end
    end

    assign trap_req   = (state_q == StTrap);
    assign mret_req   = (state_q == StMret);
    assign trap_cause = cause_q;
    assign trap_val   = val_q;
    assign trap_epc   = epc_q;
    assign mip_out    = mip;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exceptions, interrupt priority, edge/level pending, MRET, reset.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        resetn, instr_valid, illegal, mstatus_mie, trap_ack;
    logic        irq_sw, irq_timer, irq_ext;
    logic [31:0] pc, instr, mem_addr, mie;
    logic [3:0]  irq_plat;
    logic        trap_req, mret_req;
    logic [31:0] trap_cause, trap_val, trap_epc, mip_out;

    int ntests = 0;
    int nfail  = 0;

    trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .IRQ_EDGE(4'b0100)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .instr_valid (instr_valid),
        .pc          (pc),
        .instr       (instr),
        .mem_addr    (mem_addr),
        .illegal     (illegal),
        .mstatus_mie (mstatus_mie),
        .mie         (mie),
        .irq_sw      (irq_sw),
        .irq_timer   (irq_timer),
        .irq_ext     (irq_ext),
        .irq_plat    (irq_plat),
        .trap_ack    (trap_ack),
        .trap_req    (trap_req),
        .trap_cause  (trap_cause),
        .trap_val    (trap_val),
        .trap_epc    (trap_epc),
        .mret_req    (mret_req),
        .mip_out     (mip_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; instr_valid = 1'b0; illegal = 1'b0; mstatus_mie = 1'b0;
        trap_ack = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
        pc = '0; instr = 32'h0000_0013; mem_addr = '0; mie = '0; irq_plat = '0;
        step(); step();
        chk("rst_trap_req", {31'b0, trap_req}, 32'h0);
        chk("rst_mret_req", {31'b0, mret_req}, 32'h0);
        chk("rst_cause", trap_cause, 32'h0);
        chk("rst_val", trap_val, 32'h0);
        chk("rst_epc", trap_epc, 32'h0);
        chk("rst_mip", mip_out, 32'h0);
        resetn = 1'b1;
        step();

        // Misaligned word load, then frozen outputs while ECALL commits in TRAP.
        pc = 32'h100; instr = 32'h0000_A103; mem_addr = 32'h1002; instr_valid = 1'b1;
        step();
        chk("lw_req", {31'b0, trap_req}, 32'h1);
        chk("lw_cause", trap_cause, 32'd4);
        chk("lw_val", trap_val, 32'h1002);
        chk("lw_epc", trap_epc, 32'h100);
        pc = 32'h104; instr = 32'h0000_0073;
        step();
        chk("lw_hold_req", {31'b0, trap_req}, 32'h1);
        chk("lw_hold_cause", trap_cause, 32'd4);
        chk("lw_hold_epc", trap_epc, 32'h100);
        instr_valid = 1'b0; trap_ack = 1'b1;
        step();
        chk("lw_ack_fall", {31'b0, trap_req}, 32'h0);
        trap_ack = 1'b0;

        // Halfword store misaligned; byte store at the same address is fine.
        pc = 32'h200; instr = 32'h0020_9023; mem_addr = 32'h2001; instr_valid = 1'b1;
        step();
        chk("sh_cause", trap_cause, 32'd6);
        chk("sh_val", trap_val, 32'h2001);
        instr_valid = 1'b0; trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        instr = 32'h0020_8023; instr_valid = 1'b1;
        step();
        chk("sb_no_trap", {31'b0, trap_req}, 32'h0);
        // Halfword load at an even address is aligned.
        instr = 32'h0000_9103; mem_addr = 32'h3002;
        step();
        chk("lh_even_no_trap", {31'b0, trap_req}, 32'h0);
        instr_valid = 1'b0;

        // Edge-mode plat[2] one-cycle pulse.
        mie = 32'h0004_0000; mstatus_mie = 1'b1;
        irq_plat = 4'b0100;
        step();
        irq_plat = 4'b0000;
        step();
        chk("edge_n2_not_set", mip_out, 32'h0);
        step();
        chk("edge_n3_set", mip_out, 32'h0004_0000);
        step();
        chk("edge_sticky", mip_out, 32'h0004_0000);
        pc = 32'h300; instr = 32'h0000_0013; instr_valid = 1'b1;
        step();
        chk("plat2_req", {31'b0, trap_req}, 32'h1);
        chk("plat2_cause", trap_cause, 32'h8000_0012);
        chk("plat2_val", trap_val, 32'h0);
        chk("plat2_epc", trap_epc, 32'h300);
        instr_valid = 1'b0; trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        chk("plat2_cleared", mip_out, 32'h0);

        // Level-mode plat[1] follows the source.
        irq_plat = 4'b0010;
        step();
        chk("level_n1", mip_out, 32'h0);
        step();
        chk("level_n2", mip_out, 32'h0002_0000);
        step(); step(); step();
        chk("level_hold", mip_out, 32'h0002_0000);
        irq_plat = 4'b0000;
        step(); step();
        chk("level_drop", mip_out, 32'h0);

        // MEIP beats MTIP beats illegal instruction.
        mie = 32'h0000_0880; irq_ext = 1'b1; irq_timer = 1'b1;
        step(); step();
        chk("ext_tmr_mip", mip_out, 32'h0000_0880);
        pc = 32'h400; instr = 32'hFFFF_FFFF; illegal = 1'b1; instr_valid = 1'b1;
        step();
        chk("ext_cause", trap_cause, 32'h8000_000B);
        chk("ext_epc", trap_epc, 32'h400);
        instr_valid = 1'b0; trap_ack = 1'b1; irq_ext = 1'b0;
        step();
        trap_ack = 1'b0;
        step(); step();
        pc = 32'h404; instr_valid = 1'b1;
        step();
        chk("tmr_cause", trap_cause, 32'h8000_0007);
        chk("tmr_epc", trap_epc, 32'h404);
        instr_valid = 1'b0; trap_ack = 1'b1; irq_timer = 1'b0;
        step();
        trap_ack = 1'b0; illegal = 1'b0;
        step(); step();

        // MRET pulse.
        pc = 32'h500; instr = 32'h3020_0073; instr_valid = 1'b1;
        step();
        chk("mret_pulse", {31'b0, mret_req}, 32'h1);
        chk("mret_no_trap", {31'b0, trap_req}, 32'h0);
        instr_valid = 1'b0;
        step();
        chk("mret_one_cycle", {31'b0, mret_req}, 32'h0);

        // Remaining exception codes, with a back-to-back request after ack.
        pc = 32'h602; instr = 32'hFFFF_FFFF; illegal = 1'b1; instr_valid = 1'b1;
        step();
        chk("pcmis_cause", trap_cause, 32'h0);
        chk("pcmis_val", trap_val, 32'h602);
        pc = 32'h600; illegal = 1'b0; instr = 32'h0010_0073; trap_ack = 1'b1;
        step();
        chk("b2b_gap", {31'b0, trap_req}, 32'h0);
        trap_ack = 1'b0;
        step();
        chk("b2b_req", {31'b0, trap_req}, 32'h1);
        chk("ebreak_cause", trap_cause, 32'd3);
        chk("ebreak_val", trap_val, 32'h600);
        instr = 32'hDEAD_BEEF; illegal = 1'b1; trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        step();
        chk("illegal_cause", trap_cause, 32'd2);
        chk("illegal_val", trap_val, 32'hDEAD_BEEF);
        instr_valid = 1'b0; illegal = 1'b0; trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;

        // Reset in the middle of a trap, with an edge bit pending.
        mstatus_mie = 1'b0; mie = 32'h0004_0000;
        irq_plat = 4'b0100;
        step();
        irq_plat = 4'b0000;
        step(); step();
        chk("pre_rst_edge", mip_out, 32'h0004_0000);
        pc = 32'h700; instr = 32'h0000_0073; instr_valid = 1'b1;
        step();
        chk("ecall_cause", trap_cause, 32'd11);
        chk("ecall_val", trap_val, 32'h0);
        instr_valid = 1'b0;
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, trap_req}, 32'h0);
        chk("async_rst_cause", trap_cause, 32'h0);
        chk("async_rst_epc", trap_epc, 32'h0);
        chk("async_rst_mip", mip_out, 32'h0);
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_mip", mip_out, 32'h0);
        chk("post_rst_req", {31'b0, trap_req}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1);
    end

endmodule
